binary_to_gray_stream_encoder: RTL and testbench
================================================

// Module: binary_to_gray_stream_encoder
// PURPOSE
//  Streaming Binary-to-Gray encoder; the counterpart of our Gray-to-Binary converters.
//  Accepts binary words on a valid/ready input and registers gray = bin ^ (bin >> 1).
//  Presents gray words on a valid/ready output through a 2-entry skid buffer,
//  giving full throughput under backpressure.
//  Checks that consecutive output words differ by at most one bit, as a guard for
//  Gray-coded CDC pointers. Sits between pointer/counter logic and synchronisers.
// PARAMETERS
//  DATA_WIDTH  16  word width in bits (legal: >= 2)
// PORTS
//  Clock_In          input   1           single clock; all state on rising edge
//  Reset_N_In        input   1           asynchronous, active-low reset
//  Enable_In         input   1           1 = operate; 0 = hold state, tri-state data output
//  Binary_Valid_In   input   1           input word valid
//  Binary_Ready_Out  output  1           block can accept a word
//  Binary_Data_In    input   DATA_WIDTH  binary word
//  Gray_Valid_Out    output  1           output word valid
//  Gray_Ready_In     input   1           downstream accepts the output word
//  Gray_Data_Out     output  DATA_WIDTH  Gray-coded word; Z when Enable_In = 0
//  Clear_Error_In    input   1           synchronous clear of Step_Error_Out
//  Step_Error_Out    output  1           sticky: consecutive output words differ in >1 bit
// BEHAVIOUR
//  Transfer rules:
//  - In-transfer  = Enable_In & Binary_Valid_In & Binary_Ready_Out.
//  - Out-transfer = Enable_In & Gray_Valid_Out & Gray_Ready_In.
//  Encoding:
//  - Encoding is done at the input. Registers hold the Gray value; no arithmetic width growth.
//  Buffer state machine (main reg M, skid reg S):
//  - EMPTY: in-transfer -> ONE.
//  - ONE: in & !out -> TWO (word into S). !in & out -> EMPTY.
//    in & out -> ONE (M reloads). Neither -> ONE.
//  - TWO: out -> ONE (S moves to M). Binary_Ready_Out = 0, so no in-transfer.
//  Output and ready equations:
//  - Gray_Valid_Out = Enable_In & (state != EMPTY).
//  - Binary_Ready_Out = Enable_In & (state != TWO); registered state only, no combinational path
//    from Gray_Ready_In.
//  - Gray_Data_Out = Enable_In ? M : {DATA_WIDTH{1'bz}}.
//  Latency and ordering:
//  - Word accepted at edge N is visible at Gray_Data_Out after edge N (1 cycle) when the buffer
//    was EMPTY, or was ONE with a simultaneous out-transfer.
//  - Strict FIFO order; no words dropped or duplicated.
//  - Sustained 1 word/cycle when Gray_Ready_In = 1.
//  Enable_In = 0:
//  - No transfers. M, S, state, step reference and error all hold.
//  - Valid/ready outputs read 0; data output is Z.
//  - Resumes with identical contents when re-enabled.
//  Step check:
//  - On each out-transfer, if a reference word R exists, compare popcount(M ^ R).
//  - If popcount > 1, Step_Error_Out = 1 from the next cycle. Repeats (popcount 0) are legal.
//  - On each out-transfer, R <= M. The first word after reset has no reference.
//  - Clear_Error_In clears the flag next cycle; if a new error arrives the same cycle, set wins.
//  Reset (async assert, sync-safe deassert):
//  - State EMPTY; M, S and R = 0; reference invalid; Step_Error_Out = 0.
//  - Gray_Valid_Out = 0.
//  - Binary_Ready_Out = Enable_In. During reset it is held at 0.
//  - Gray_Data_Out = 0, or Z if Enable_In = 0.
//  - Reset mid-operation discards buffered words immediately; no partial output.
// TESTING
//  T1 stream: bin 0x0000..0x0007, Gray_Ready_In = 1 -> gray 0000,0001,0003,0002,0006,0007,0005,0004;
//     one per cycle, 1-cycle latency, Step_Error_Out = 0.
//  T2 backpressure: Gray_Ready_In = 0 for 3 cycles; offer 0x1234, 0x1235, 0x1236 ->
//     two accepted, then Binary_Ready_Out = 0.
//     On release, outputs 0x1B2E, 0x1B2F, 0x1B2D in order.
//  T3 step error: send 0x0000 then 0x0005 -> gray 0x0000, 0x0007.
//     Step_Error_Out = 1 the cycle after the 2nd out-transfer.
//     Pulse Clear_Error_In -> flag 0. Set + clear in the same cycle -> flag stays 1.
//  T4 enable: Enable_In = 0 with one word held -> Gray_Data_Out = Z, valid/ready = 0.
//     Re-enable -> same word presented, nothing lost.
//  T5 reset mid-op: buffer TWO, assert Reset_N_In = 0 mid-cycle -> Gray_Valid_Out = 0 immediately.
//     After release, the first word raises no step error regardless of value.
//  T6 extremes: bin 0xFFFF -> 0x8000; bin 0x8000 -> 0xC000; back-to-back -> no step error (1 bit).

Source files
------------

// File: rtl/binary_to_gray_stream_encoder.sv
// binary_to_gray_stream_encoder
//
// Streaming binary-to-Gray encoder. Binary words arrive on a valid/ready
// input, are encoded (gray = bin ^ (bin >> 1)) on the way in, and leave on a
// valid/ready output through a two-entry skid buffer. The skid buffer keeps
// the input ready registered-only (no combinational path from Gray_Ready_In)
// while still sustaining one word per cycle.
//
// Consecutive output words are compared; if any two differ in more than one
// bit a sticky Step_Error_Out is raised. This protects Gray-coded CDC
// pointers feeding synchronisers.
//
// Ports
//   Clock_In          single clock, rising edge
//   Reset_N_In        asynchronous active-low reset
//   Enable_In         1 = operate, 0 = freeze all state and float the data bus
//   Binary_Valid_In   input word valid
//   Binary_Ready_Out  block can accept a word
//   Binary_Data_In    binary input word
//   Gray_Valid_Out    output word valid
//   Gray_Ready_In     downstream accepts the output word
//   Gray_Data_Out     Gray-coded output word, Z when disabled
//   Clear_Error_In    synchronous clear of Step_Error_Out
//   Step_Error_Out    sticky multi-bit-step flag
//
// Buffer states
//   state    | meaning
//   ST_EMPTY | no word held, output invalid
//   ST_ONE   | one word in main register M
//   ST_TWO   | M full and skid register S full, input stalled

module binary_to_gray_stream_encoder #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clock_In,
    input  logic                  Reset_N_In,
    input  logic                  Enable_In,
    input  logic                  Binary_Valid_In,
    output logic                  Binary_Ready_Out,
    input  logic [DATA_WIDTH-1:0] Binary_Data_In,
    output logic                  Gray_Valid_Out,
    input  logic                  Gray_Ready_In,
    output logic [DATA_WIDTH-1:0] Gray_Data_Out,
    input  logic                  Clear_Error_In,
    output logic                  Step_Error_Out
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE_W = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] m_q, m_d;
    logic [DATA_WIDTH-1:0] s_q, s_d;
    logic [DATA_WIDTH-1:0] r_q, r_d;
    logic                  ref_valid_q, ref_valid_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] gray_in;
    logic [DATA_WIDTH-1:0] step_diff;
    logic                  multi_bit_step;
    logic                  in_xfer;
    logic                  out_xfer;

    assign gray_in = Binary_Data_In ^ (Binary_Data_In >> 1);

    // Ready is gated by reset so an upstream source never sees a handshake
    // while the buffer is being held in reset.
    assign Binary_Ready_Out = Enable_In & Reset_N_In & (state_q != ST_TWO);
    assign Gray_Valid_Out   = Enable_In & (state_q != ST_EMPTY);
    assign Gray_Data_Out    = Enable_In ? m_q : {DATA_WIDTH{1'bz}};
    assign Step_Error_Out   = err_q;

    assign in_xfer  = Enable_In & Binary_Valid_In & Binary_Ready_Out;
    assign out_xfer = Enable_In & Gray_Valid_Out & Gray_Ready_In;

    // x & (x - 1) clears the lowest set bit; anything left means >1 bit set.
    assign step_diff      = m_q ^ r_q;
    assign multi_bit_step = |(step_diff & (step_diff - ONE_W));

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        s_d         = s_q;
        r_d         = r_q;
        ref_valid_d = ref_valid_q;
        err_d       = err_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    m_d     = gray_in;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && !out_xfer) begin
                    s_d     = gray_in;
                    state_d = ST_TWO;
                end else if (in_xfer && out_xfer) begin
                    m_d = gray_in;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    m_d     = s_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (out_xfer) begin
            r_d         = m_q;
            ref_valid_d = 1'b1;
        end

        // A fresh error in the same cycle as a clear wins.
        if (Enable_In) begin
            err_d = (err_q & ~Clear_Error_In) |
                    (out_xfer & ref_valid_q & multi_bit_step);
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q     <= ST_EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            r_q         <= '0;
            ref_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            r_q         <= r_d;
            ref_valid_q <= ref_valid_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_binary_to_gray_stream_encoder.sv
// Scoreboarded bench for binary_to_gray_stream_encoder: the driver pushes the
// hand-computed Gray word whenever a binary word is accepted; an independent
// monitor pops and compares on every output transfer.

module tb_binary_to_gray_stream_encoder;

    logic        Clock_In;
    logic        Reset_N_In;
    logic        Enable_In;
    logic        Binary_Valid_In;
    logic        Binary_Ready_Out;
    logic [15:0] Binary_Data_In;
    logic        Gray_Valid_Out;
    logic        Gray_Ready_In;
    wire  [15:0] Gray_Data_Out;
    logic        Clear_Error_In;
    logic        Step_Error_Out;

    binary_to_gray_stream_encoder #(.DATA_WIDTH(16)) dut (
        .Clock_In        (Clock_In),
        .Reset_N_In      (Reset_N_In),
        .Enable_In       (Enable_In),
        .Binary_Valid_In (Binary_Valid_In),
        .Binary_Ready_Out(Binary_Ready_Out),
        .Binary_Data_In  (Binary_Data_In),
        .Gray_Valid_Out  (Gray_Valid_Out),
        .Gray_Ready_In   (Gray_Ready_In),
        .Gray_Data_Out   (Gray_Data_Out),
        .Clear_Error_In  (Clear_Error_In),
        .Step_Error_Out  (Step_Error_Out)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [15:0] sb[$];

    initial Clock_In = 1'b0;
    always #5 Clock_In = ~Clock_In;
    always @(posedge Clock_In) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every output transfer must match the oldest expected word.
    always @(negedge Clock_In) begin
        if (Reset_N_In && Enable_In && Gray_Valid_Out && Gray_Ready_In) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %0h expected none at %0t", Gray_Data_Out, $time);
            end else begin
                chk("gray_out", {16'h0, Gray_Data_Out}, {16'h0, sb.pop_front()});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge,
    // with valid still high so back-to-back calls stream one word per cycle.
    task automatic send_word(input logic [15:0] bin, input logic [15:0] exp_gray);
        bit done = 0;
        Binary_Valid_In = 1'b1;
        Binary_Data_In  = bin;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge Clock_In);
            if (Binary_Ready_Out && Enable_In) begin
                sb.push_back(exp_gray);
                @(posedge Clock_In);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 for %0h", bin);
            @(posedge Clock_In);
            #1;
        end
    endtask

    task automatic idle(input int n);
        Binary_Valid_In = 1'b0;
        repeat (n) begin
            @(posedge Clock_In);
            #1;
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge Clock_In);
            #1;
            if (sb.size() == 0 && !Gray_Valid_Out) done = 1;
        end
        chk(name, {31'h0, done}, 32'h1);
    endtask

    task automatic do_reset();
        Binary_Valid_In = 1'b0;
        Clear_Error_In  = 1'b0;
        Reset_N_In      = 1'b0;
        #1;
        chk("rst_valid", {31'h0, Gray_Valid_Out}, 32'h0);
        chk("rst_ready_held", {31'h0, Binary_Ready_Out}, 32'h0);
        sb.delete();
        @(negedge Clock_In);
        Reset_N_In = 1'b1;
        #1;
        chk("rst_ready", {31'h0, Binary_Ready_Out}, 32'h1);
        chk("rst_err", {31'h0, Step_Error_Out}, 32'h0);
        chk("rst_data", {16'h0, Gray_Data_Out}, 32'h0);
        @(posedge Clock_In);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [15:0] t1_gray [8] = '{16'h0000, 16'h0001, 16'h0003, 16'h0002,
                                     16'h0006, 16'h0007, 16'h0005, 16'h0004};
        Reset_N_In      = 1'b0;
        Enable_In       = 1'b1;
        Binary_Valid_In = 1'b0;
        Binary_Data_In  = '0;
        Gray_Ready_In   = 1'b1;
        Clear_Error_In  = 1'b0;
        repeat (2) @(posedge Clock_In);
        #1;
        do_reset();

        // T1: stream 0..7 at full rate
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
            send_word(16'(i), t1_gray[i]);
            if (i == 0) chk("t1_latency", {31'h0, Gray_Valid_Out}, 32'h1);
        end
        chk("t1_throughput", cyc - t0, 32'd8);
        idle(1);
        wait_drain("t1_drain");
        chk("t1_err", {31'h0, Step_Error_Out}, 32'h0);

        // T2: backpressure fills both entries
        do_reset();
        Gray_Ready_In = 1'b0;
        send_word(16'h1234, 16'h1B2E);
        send_word(16'h1235, 16'h1B2F);
        Binary_Data_In = 16'h1236;
        @(negedge Clock_In);
        chk("t2_ready_full", {31'h0, Binary_Ready_Out}, 32'h0);
        chk("t2_head", {16'h0, Gray_Data_Out}, 32'h1B2E);
        @(posedge Clock_In);
        #1;
        Gray_Ready_In = 1'b1;
        send_word(16'h1236, 16'h1B2D);
        idle(1);
        wait_drain("t2_drain");
        chk("t2_err", {31'h0, Step_Error_Out}, 32'h0);

        // T3: step error, clear, set-beats-clear
        do_reset();
        send_word(16'h0000, 16'h0000);
        send_word(16'h0005, 16'h0007);
        Binary_Valid_In = 1'b0;
        @(negedge Clock_In);
        chk("t3_err_before", {31'h0, Step_Error_Out}, 32'h0);
        @(posedge Clock_In);
        #1;
        chk("t3_err_set", {31'h0, Step_Error_Out}, 32'h1);
        Clear_Error_In = 1'b1;
        @(posedge Clock_In);
        #1;
        Clear_Error_In = 1'b0;
        chk("t3_err_cleared", {31'h0, Step_Error_Out}, 32'h0);
        send_word(16'h0000, 16'h0000);
        Binary_Valid_In = 1'b0;
        Clear_Error_In  = 1'b1;
        @(posedge Clock_In);
        #1;
        Clear_Error_In = 1'b0;
        chk("t3_set_wins", {31'h0, Step_Error_Out}, 32'h1);
        wait_drain("t3_drain");

        // T4: disable with a word held
        do_reset();
        Gray_Ready_In = 1'b0;
        send_word(16'h1234, 16'h1B2E);
        Binary_Data_In = 16'h4321;
        Enable_In      = 1'b0;
        Gray_Ready_In  = 1'b1;
        @(negedge Clock_In);
        chk("t4_valid_off", {31'h0, Gray_Valid_Out}, 32'h0);
        chk("t4_ready_off", {31'h0, Binary_Ready_Out}, 32'h0);
        repeat (3) @(posedge Clock_In);
        #1;
        Binary_Valid_In = 1'b0;
        Enable_In       = 1'b1;
        #1;
        chk("t4_resume_data", {16'h0, Gray_Data_Out}, 32'h1B2E);
        chk("t4_resume_valid", {31'h0, Gray_Valid_Out}, 32'h1);
        @(posedge Clock_In);
        #1;
        wait_drain("t4_drain");

        // T5: reset while full; stale reference must not flag the next word
        do_reset();
        send_word(16'h0001, 16'h0001);
        idle(1);
        Gray_Ready_In = 1'b0;
        send_word(16'h0002, 16'h0003);
        send_word(16'h0003, 16'h0002);
        Binary_Valid_In = 1'b0;
        #2;
        Reset_N_In = 1'b0;
        #1;
        chk("t5_valid_async", {31'h0, Gray_Valid_Out}, 32'h0);
        chk("t5_ready_async", {31'h0, Binary_Ready_Out}, 32'h0);
        sb.delete();
        @(negedge Clock_In);
        Reset_N_In = 1'b1;
        #1;
        chk("t5_ready_release", {31'h0, Binary_Ready_Out}, 32'h1);
        chk("t5_valid_release", {31'h0, Gray_Valid_Out}, 32'h0);
        Gray_Ready_In = 1'b1;
        @(posedge Clock_In);
        #1;
        send_word(16'h1234, 16'h1B2E);
        idle(1);
        wait_drain("t5_drain");
        chk("t5_no_err", {31'h0, Step_Error_Out}, 32'h0);

        // T6: extremes, single-bit steps
        do_reset();
        send_word(16'hFFFF, 16'h8000);
        send_word(16'h8000, 16'hC000);
        send_word(16'hFFFF, 16'h8000);
        idle(1);
        wait_drain("t6_drain");
        chk("t6_no_err", {31'h0, Step_Error_Out}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
